// File: rtl/switch_packetizer_acc.sv
// Packs WORDS_PER_FLIT Ethernet segments (LANES sub-flits each) into one NoC flit with head/tail/dest header.
// Latency: flit-completing segment accepted in cycle N -> o_valid_out in cycle N+1; partial segments emit nothing.
// Backpressure: i_ready_out = !o_valid_out | o_ready_in, forced low in the cycle a mid-packet SOP aborts the open flit.
module switch_packetizer_acc #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int LANES            = 2,
    parameter int WORDS_PER_FLIT   = 2,
    parameter int WIDTH_OUT        = 600,
    parameter int ASSIGNED_VC      = 0,
    localparam int LW              = DATA_WIDTH + 7,
    localparam int WIDTH_IN        = LANES * LW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH_IN-1:0]      i_data_in,
    input  logic                     i_valid_in,
    input  logic [ADDRESS_WIDTH-1:0] i_dest_in,
    output logic                     i_ready_out,
    output logic [WIDTH_OUT-1:0]     o_data_out,
    output logic                     o_valid_out,
    input  logic                     o_ready_in,
    output logic [15:0]              o_err_count
);
    localparam int BODY_W    = DATA_WIDTH + 5;
    localparam int SEG_W     = LANES * BODY_W;
    localparam int PAYLOAD_W = WORDS_PER_FLIT * SEG_W;
    localparam int HDR_W     = 3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH;
    localparam int USED_W    = HDR_W + PAYLOAD_W;
    localparam int SLOT_W    = (WORDS_PER_FLIT > 1) ? $clog2(WORDS_PER_FLIT) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORDS_PER_FLIT - 1);
    localparam logic [VC_ADDRESS_WIDTH-1:0] VC_BITS = VC_ADDRESS_WIDTH'(ASSIGNED_VC);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [SLOT_W-1:0]        slot_q, slot_d, wr_slot;
    logic                     head_q, head_d;
    logic [ADDRESS_WIDTH-1:0] dest_q, dest_d, flit_dest;
    logic [PAYLOAD_W-1:0]     acc_q, acc_d, merged;
    logic [SEG_W-1:0]         seg_body;
    logic                     seg_eop, seg_start, seg_sop, sop_bits_unused;
    logic                     can_take, abort, accept, write, complete, emit, drop;
    logic                     flit_head, flit_tail;
    logic [WIDTH_OUT-1:0]     flit;
    logic                     valid_q;
    logic [WIDTH_OUT-1:0]     data_q;
    logic [15:0]              err_q;

    assign seg_start = i_data_in[WIDTH_IN-1];
    assign seg_sop   = i_data_in[WIDTH_IN-2];

    // Lane bodies of invalid lanes are zeroed so unfilled payload stays clean.
    always_comb begin
        seg_body        = '0;
        seg_eop         = 1'b0;
        sop_bits_unused = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            sop_bits_unused = sop_bits_unused ^ i_data_in[WIDTH_IN-2-l*LW];
            if (i_data_in[WIDTH_IN-1-l*LW]) begin
                seg_body[SEG_W-1-l*BODY_W -: BODY_W] = i_data_in[WIDTH_IN-(l+1)*LW +: BODY_W];
                seg_eop = seg_eop | i_data_in[WIDTH_IN-3-l*LW];
            end
        end
    end

    assign can_take    = !valid_q | o_ready_in;
    assign abort       = i_valid_in & seg_start & seg_sop & (state_q == ACCUM) & can_take;
    assign i_ready_out = can_take & !abort;
    assign accept      = i_valid_in & i_ready_out;
    assign write       = accept & seg_start & (seg_sop | (state_q == ACCUM));
    assign drop        = accept & seg_start & !seg_sop & (state_q == IDLE);
    assign wr_slot     = (state_q == IDLE) ? '0 : slot_q;
    assign complete    = write & (seg_eop | (wr_slot == LAST_SLOT));
    assign emit        = complete | abort;
    assign flit_head   = (state_q == IDLE) | head_q;
    assign flit_tail   = abort | seg_eop;
    assign flit_dest   = (state_q == IDLE) ? i_dest_in : dest_q;

    always_comb begin
        merged = acc_q;
        if (write) begin
            merged[PAYLOAD_W-1-int'(wr_slot)*SEG_W -: SEG_W] = seg_body;
        end
        flit = '0;
        flit[WIDTH_OUT-1 -: USED_W] = {1'b1, flit_head, flit_tail, VC_BITS, flit_dest, merged};
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        head_d  = head_q;
        dest_d  = dest_q;
        acc_d   = acc_q;
        if (abort) begin
            state_d = IDLE;
            slot_d  = '0;
            head_d  = 1'b0;
            acc_d   = '0;
        end else if (write) begin
            if (state_q == IDLE) begin
                dest_d = i_dest_in;
                head_d = 1'b1;
            end
            if (complete) begin
                acc_d   = '0;
                slot_d  = '0;
                head_d  = 1'b0;
                state_d = seg_eop ? IDLE : ACCUM;
            end else begin
                acc_d   = merged;
                slot_d  = wr_slot + 1'b1;
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            head_q  <= 1'b0;
            dest_q  <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            head_q  <= head_d;
            dest_q  <= dest_d;
            acc_q   <= acc_d;
            if (emit) begin
                valid_q <= 1'b1;
                data_q  <= flit;
            end else if (o_ready_in) begin
                valid_q <= 1'b0;
            end
            if ((drop | abort) && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign o_valid_out = valid_q;
    assign o_data_out  = data_q;
    assign o_err_count = err_q;
endmodule

// File: tb/tb_switch_packetizer_acc.sv
// Randomized bench for switch_packetizer_acc against a packet-level reference model.
module tb_switch_packetizer_acc;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_W     = 4;
    localparam int LANES      = 2;
    localparam int WPF        = 2;
    localparam int WIDTH_OUT  = 600;
    localparam int LW         = DATA_WIDTH + 7;
    localparam int WIDTH_IN   = LANES * LW;
    localparam int BODY_W     = DATA_WIDTH + 5;
    localparam int SEG_W      = LANES * BODY_W;
    localparam int PAYLOAD_W  = WPF * SEG_W;
    localparam int PAD_W      = WIDTH_OUT - (3 + 1 + ADDR_W + PAYLOAD_W);

    localparam int K_IDLE = 0, K_NOSTART = 1, K_SOP = 2, K_MID = 3, K_EOP = 4, K_SOPEOP = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [WIDTH_IN-1:0]  i_data_in;
    logic                 i_valid_in;
    logic [ADDR_W-1:0]    i_dest_in;
    logic                 i_ready_out;
    logic [WIDTH_OUT-1:0] o_data_out;
    logic                 o_valid_out;
    logic                 o_ready_in;
    logic [15:0]          o_err_count;

    switch_packetizer_acc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data_in   (i_data_in),
        .i_valid_in  (i_valid_in),
        .i_dest_in   (i_dest_in),
        .i_ready_out (i_ready_out),
        .o_data_out  (o_data_out),
        .o_valid_out (o_valid_out),
        .o_ready_in  (o_ready_in),
        .o_err_count (o_err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state: open packet, its collected segment bodies, output stage
    bit                   m_open      = 0;
    bit                   m_head_done = 0;
    logic [ADDR_W-1:0]    m_dest      = '0;
    logic [SEG_W-1:0]     m_parts[$];
    bit                   m_ov        = 0;
    logic [WIDTH_OUT-1:0] m_od        = '0;
    logic [15:0]          m_err       = '0;
    bit                   m_acc       = 0;
    bit                   m_rst_seen  = 0;

    // attributes of the segment currently on the input
    bit               cur_l0v, cur_sop, cur_eop;
    logic [SEG_W-1:0] cur_body;

    task automatic check_eq(input string tag, input logic [WIDTH_OUT-1:0] got,
                            input logic [WIDTH_OUT-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH_OUT-1:0] make_flit(bit head, bit tail, logic [ADDR_W-1:0] dest);
        logic [PAYLOAD_W-1:0] p;
        logic [WIDTH_OUT-1:0] f;
        p = '0;
        foreach (m_parts[i]) p = (p << SEG_W) | PAYLOAD_W'(m_parts[i]);
        p = p << ((WPF - m_parts.size()) * SEG_W);
        f = WIDTH_OUT'({1'b1, head, tail, 1'b0, dest});
        f = (f << PAYLOAD_W) | WIDTH_OUT'(p);
        return f << PAD_W;
    endfunction

    function automatic void err_inc();
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
    endfunction

    task automatic gen_seg(input int kind);
        bit v, s, e, l0v, sop_k, eop_k;
        int eop_lane;
        logic [2:0] empty;
        bit er;
        logic [DATA_WIDTH-1:0] d;
        i_data_in = '0;
        cur_body  = '0;
        cur_eop   = 0;
        l0v   = (kind != K_NOSTART);
        sop_k = (kind == K_SOP) || (kind == K_SOPEOP);
        eop_k = (kind == K_EOP) || (kind == K_SOPEOP);
        eop_lane = eop_k ? int'($urandom_range(0, LANES - 1)) : -1;
        for (int l = 0; l < LANES; l++) begin
            v = (l == 0) ? l0v : ((l == eop_lane) ? 1'b1 : 1'($urandom_range(0, 1)));
            s = (l == 0 && l0v) ? sop_k : 1'($urandom_range(0, 1));
            e = v ? (l == eop_lane) : 1'($urandom_range(0, 1));
            empty = 3'($urandom_range(0, 7));
            er    = 1'($urandom_range(0, 1));
            d     = DATA_WIDTH'({$urandom(), $urandom()});
            i_data_in = (i_data_in << LW) | WIDTH_IN'({v, s, e, empty, er, d});
            cur_body  = (cur_body << BODY_W) | (v ? SEG_W'({e, empty, er, d}) : '0);
            cur_eop   = cur_eop | (v & e);
            if (l == 0) cur_sop = s;
        end
        cur_l0v    = l0v;
        i_valid_in = (kind != K_IDLE);
    endtask

    task automatic model_step();
        bit can, abort, emit, exp_rdy;
        logic [WIDTH_OUT-1:0] nf;
        emit = 0;
        nf   = '0;
        if (!rst_n) begin
            m_open = 0; m_head_done = 0; m_parts.delete();
            m_ov = 0; m_od = '0; m_err = '0; m_acc = 0; m_rst_seen = 1;
            return;
        end
        can     = !m_ov || o_ready_in;
        abort   = i_valid_in && cur_l0v && cur_sop && m_open && can;
        exp_rdy = can && !abort;
        check_eq("ready", i_ready_out, exp_rdy);
        m_acc = i_valid_in && exp_rdy;
        if (abort) begin
            nf = make_flit(!m_head_done, 1'b1, m_dest);
            emit = 1;
            m_parts.delete();
            m_open = 0;
            err_inc();
        end else if (m_acc && cur_l0v) begin
            if (!m_open && !cur_sop) begin
                err_inc();
            end else begin
                if (!m_open) begin
                    m_open = 1; m_dest = i_dest_in; m_head_done = 0;
                end
                m_parts.push_back(cur_body);
                if (cur_eop || m_parts.size() == WPF) begin
                    nf = make_flit(!m_head_done, cur_eop, m_dest);
                    emit = 1;
                    m_head_done = 1;
                    m_parts.delete();
                    if (cur_eop) m_open = 0;
                end
            end
        end
        if (emit) begin
            m_ov = 1; m_od = nf;
        end else if (o_ready_in) begin
            m_ov = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        check_eq("valid", o_valid_out, m_ov);
        if (m_ov || m_rst_seen) check_eq("data", o_data_out, m_od);
        check_eq("err_count", o_err_count, m_err);
        m_rst_seen = 0;
    endtask

    task automatic send(input int kind, input logic [ADDR_W-1:0] dest);
        bit done;
        done = 0;
        gen_seg(kind);
        i_dest_in = dest;
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            done = m_acc || (kind == K_IDLE);
        end
        check_eq("send_accept", done, 1);
        i_valid_in = 0;
    endtask

    function automatic int pick_kind(bit open);
        int r;
        r = $urandom_range(0, 99);
        if (open) return (r < 45) ? K_MID : (r < 70) ? K_EOP : (r < 78) ? K_SOP :
                         (r < 83) ? K_SOPEOP : (r < 93) ? K_IDLE : K_NOSTART;
        return (r < 40) ? K_SOP : (r < 55) ? K_SOPEOP : (r < 65) ? K_MID :
               (r < 75) ? K_EOP : (r < 90) ? K_IDLE : K_NOSTART;
    endfunction

    logic [WIDTH_OUT-1:0] bp_flit;

    initial begin
        rst_n = 0; o_ready_in = 1; i_valid_in = 0; i_data_in = '0; i_dest_in = '0;
        cur_l0v = 0; cur_sop = 0; cur_eop = 0; cur_body = '0;
        tick(); tick();
        rst_n = 1;
        check_eq("reset_valid", o_valid_out, 0);
        check_eq("reset_data", o_data_out, '0);
        check_eq("reset_err", o_err_count, 0);
        check_eq("reset_ready", i_ready_out, 1);

        // 4-segment packet, downstream always ready
        send(K_SOP, 4'd5); send(K_MID, 4'd1); send(K_MID, 4'd2); send(K_EOP, 4'd3);
        send(K_IDLE, 4'd0); send(K_IDLE, 4'd0);
        // 3-segment packet with dest changing mid-packet
        send(K_SOP, 4'd6); send(K_MID, 4'd9); send(K_EOP, 4'd12); send(K_IDLE, 4'd0);
        // single-segment packet
        send(K_SOPEOP, 4'd8); send(K_IDLE, 4'd0);
        // drop in IDLE, then abort by SOP inside an open flit
        send(K_MID, 4'd0); send(K_IDLE, 4'd0);
        check_eq("drop_err", o_err_count, 1);
        send(K_SOP, 4'd2); send(K_SOP, 4'd7);
        check_eq("abort_err", o_err_count, 2);
        send(K_EOP, 4'd0); send(K_IDLE, 4'd0);

        // downstream stall with a flit pending
        o_ready_in = 0;
        send(K_SOPEOP, 4'd3);
        bp_flit = m_od;
        gen_seg(K_SOP);
        i_dest_in = 4'd4;
        for (int n = 0; n < 5; n++) begin
            tick();
            check_eq("stall_hold", o_data_out, bp_flit);
        end
        o_ready_in = 1;
        for (int n = 0; n < 10 && !m_acc; n++) tick();
        check_eq("stall_accept", m_acc, 1);
        i_valid_in = 0;
        send(K_EOP, 4'd0); send(K_IDLE, 4'd0);

        // reset in the middle of a packet
        send(K_SOP, 4'd9); send(K_MID, 4'd0); send(K_MID, 4'd0);
        check_eq("pre_reset_err", o_err_count, 2);
        rst_n = 0;
        tick();
        rst_n = 1;
        check_eq("midrst_valid", o_valid_out, 0);
        check_eq("midrst_err", o_err_count, 0);
        send(K_MID, 4'd0); send(K_IDLE, 4'd0);
        check_eq("post_reset_drop", o_err_count, 1);

        // randomized traffic with backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            if (!i_valid_in || m_acc) begin
                gen_seg(pick_kind(m_open));
                i_dest_in = 4'($urandom_range(0, 15));
            end
            o_ready_in = ((c % 1000) < 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
            if (!rst_n) i_valid_in = 0;
            tick();
        end
        rst_n = 1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
